ssd1351_spi_sink: RTL

Receive-side model of the SSD1351 OLED controller's 4-wire SPI link: it oversamples the `spi_csn/spi_clk/spi_mosi/spi_dc/spi_resn` lines that our OLED video driver produces. It decodes command and data bytes and emits one pixel write (x, y, 16-bit RGB565) per received pixel. It sits on the FPGA side of the same pins, feeding a BRAM mirror or scoreboard, so frames sent to the panel can be displayed elsewhere (e.g. VGA) or checked in simulation.

---
 rtl/ssd1351_spi_sink.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ssd1351_spi_sink.sv
// -----------------------------------------------------------------------------
// ssd1351_spi_sink
//
// Receive-side model of the SSD1351 4-wire SPI link. The block oversamples the
// SPI pins in the clk domain, deserialises command/data bytes and turns the
// RAM-write stream into one pixel write (x, y, RGB565) per received pixel. It
// listens on the same pins the OLED video driver drives, so a frame sent to
// the panel can be mirrored into BRAM or checked in simulation.
//
// Parameters
//   c_x_size / c_y_size : panel columns / rows
//   c_x_bits / c_y_bits : width of pix_x / pix_y (at most 8)
//
// Ports
//   clk          system clock; SPI clock must be no faster than clk/4
//   rst          asynchronous active-high reset
//   spi_csn      chip select, active low        (asynchronous to clk)
//   spi_clk      SPI clock, sampled on rising edge (mode 0/3)
//   spi_mosi     serial data, MSB first
//   spi_dc       0 = command byte, 1 = data byte, taken with bit 0
//   spi_resn     panel reset, active low; clears everything but the syncs
//   cmd_valid    one-cycle pulse per received command byte
//   cmd_byte     last command byte, held until the next command
//   pix_we       one-cycle pixel write strobe
//   pix_x/pix_y  pixel coordinate, updated only with pix_we
//   pix_color    RGB565 colour, updated only with pix_we
//   frame_done   pulse together with pix_we of the pixel at (col_end,row_end)
// -----------------------------------------------------------------------------
module ssd1351_spi_sink #(
   parameter int c_x_size = 128,
   parameter int c_y_size = 128,
   parameter int c_x_bits = 7,
   parameter int c_y_bits = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                spi_csn,
   input  logic                spi_clk,
   input  logic                spi_mosi,
   input  logic                spi_dc,
   input  logic                spi_resn,
   output logic                cmd_valid,
   output logic [7:0]          cmd_byte,
   output logic                pix_we,
   output logic [c_x_bits-1:0] pix_x,
   output logic [c_y_bits-1:0] pix_y,
   output logic [15:0]         pix_color,
   output logic                frame_done
);

   localparam logic [c_x_bits-1:0] c_x_last = c_x_bits'(c_x_size - 1);
   localparam logic [c_y_bits-1:0] c_y_last = c_y_bits'(c_y_size - 1);

   localparam logic [7:0] c_cmd_set_col = 8'h15;
   localparam logic [7:0] c_cmd_set_row = 8'h75;
   localparam logic [7:0] c_cmd_write   = 8'h5C;

   // The five SPI lines travel together through the synchronizer chain.
   typedef struct packed {
      logic resn;
      logic dc;
      logic mosi;
      logic sclk;
      logic csn;
   } spi_lines_t;

   // Idle levels: deselected, panel out of reset, clock low.
   localparam spi_lines_t c_lines_idle = '{resn: 1'b1, dc: 1'b0, mosi: 1'b0,
                                           sclk: 1'b0, csn: 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARG,
      ST_WRITE
   } state_t;

   // All decoder state in one record so both reset sources clear it with a
   // single assignment.
   typedef struct packed {
      state_t              state;
      logic                arg_row;     // current ARG command targets rows
      logic                arg_second;  // first argument already received
      logic                pending;     // high byte of a pixel is stored
      logic [7:0]          hi;
      logic [c_x_bits-1:0] col_start;
      logic [c_x_bits-1:0] col_end;
      logic [c_y_bits-1:0] row_start;
      logic [c_y_bits-1:0] row_end;
      logic [c_x_bits-1:0] x;
      logic [c_y_bits-1:0] y;
      logic                cmd_valid;
      logic [7:0]          cmd_byte;
      logic                pix_we;
      logic [c_x_bits-1:0] pix_x;
      logic [c_y_bits-1:0] pix_y;
      logic [15:0]         pix_color;
      logic                frame_done;
   } dec_t;

   localparam dec_t c_dec_rst = '{
      state:      ST_IDLE,
      arg_row:    1'b0,
      arg_second: 1'b0,
      pending:    1'b0,
      hi:         8'h00,
      col_start:  '0,
      col_end:    c_x_last,
      row_start:  '0,
      row_end:    c_y_last,
      x:          '0,
      y:          '0,
      cmd_valid:  1'b0,
      cmd_byte:   8'h00,
      pix_we:     1'b0,
      pix_x:      '0,
      pix_y:      '0,
      pix_color:  16'h0000,
      frame_done: 1'b0
   };

   spi_lines_t r_s1, r_s2, r_s3;
   logic       r_rise;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_byte_vld;
   logic [7:0] r_byte;
   logic       r_byte_dc;
   dec_t       r_dec;

   logic                w_soft_rst;
   logic [c_x_bits-1:0] w_x_inc;
   logic [c_y_bits-1:0] w_y_inc;

   // -------------------------------------------------------------------------
   // Synchronizers: two flops for metastability, a third for edge detection.
   // Only rst clears them, so spi_resn itself keeps being sampled.
   // -------------------------------------------------------------------------
   // NOTE: every clocked register uses non-blocking assignment so all flops
   // update from pre-edge values and the chain shifts by exactly one stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= c_lines_idle;
         r_s2 <= c_lines_idle;
         r_s3 <= c_lines_idle;
      end else begin
         r_s1 <= '{resn: spi_resn, dc: spi_dc, mosi: spi_mosi,
                   sclk: spi_clk, csn: spi_csn};
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_soft_rst = ~r_s3.resn;

   // -------------------------------------------------------------------------
   // Deserializer. r_rise is registered one cycle after the edge becomes
   // visible; on the following cycle r_s3 holds the mosi/dc/csn values that
   // were on the pins when the edge was captured, so data and edge line up.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rise     <= 1'b0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_byte_vld <= 1'b0;
         r_byte     <= '0;
         r_byte_dc  <= 1'b0;
      end else if (w_soft_rst) begin
         r_rise     <= 1'b0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_byte_vld <= 1'b0;
         r_byte     <= '0;
         r_byte_dc  <= 1'b0;
      end else begin
         r_rise     <= r_s2.sclk & ~r_s3.sclk;
         r_byte_vld <= 1'b0;
         if (r_s3.csn) begin
            // Deselect drops any partial byte; the decoder keeps its state.
            r_bit_cnt <= '0;
         end else if (r_rise) begin
            r_shift   <= {r_shift[6:0], r_s3.mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_byte_vld <= 1'b1;
               r_byte     <= {r_shift[6:0], r_s3.mosi};
               r_byte_dc  <= r_s3.dc;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Command decoder and address generator.
   // -------------------------------------------------------------------------
   // Outside the programmed window the address runs up to the panel edge and
   // wraps to zero; only reaching the window end jumps back to its start.
   assign w_x_inc = (r_dec.x == c_x_last) ? '0 : r_dec.x + 1'b1;
   assign w_y_inc = (r_dec.y == c_y_last) ? '0 : r_dec.y + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dec <= c_dec_rst;
      end else if (w_soft_rst) begin
         r_dec <= c_dec_rst;
      end else begin
         r_dec.cmd_valid  <= 1'b0;
         r_dec.pix_we     <= 1'b0;
         r_dec.frame_done <= 1'b0;
         if (r_byte_vld) begin
            if (!r_byte_dc) begin
               // A command always abandons a half-received pixel.
               r_dec.cmd_valid <= 1'b1;
               r_dec.cmd_byte  <= r_byte;
               r_dec.pending   <= 1'b0;
               case (r_byte)
                  c_cmd_set_col: begin
                     r_dec.state      <= ST_ARG;
                     r_dec.arg_row    <= 1'b0;
                     r_dec.arg_second <= 1'b0;
                  end
                  c_cmd_set_row: begin
                     r_dec.state      <= ST_ARG;
                     r_dec.arg_row    <= 1'b1;
                     r_dec.arg_second <= 1'b0;
                  end
                  c_cmd_write: begin
                     r_dec.state <= ST_WRITE;
                     r_dec.x     <= r_dec.col_start;
                     r_dec.y     <= r_dec.row_start;
                  end
                  default: r_dec.state <= ST_IDLE;
               endcase
            end else begin
               case (r_dec.state)
                  ST_ARG: begin
                     if (!r_dec.arg_second) begin
                        if (r_dec.arg_row) r_dec.row_start <= r_byte[c_y_bits-1:0];
                        else               r_dec.col_start <= r_byte[c_x_bits-1:0];
                        r_dec.arg_second <= 1'b1;
                     end else begin
                        if (r_dec.arg_row) r_dec.row_end <= r_byte[c_y_bits-1:0];
                        else               r_dec.col_end <= r_byte[c_x_bits-1:0];
                        r_dec.state <= ST_IDLE;
                     end
                  end
                  ST_WRITE: begin
                     if (!r_dec.pending) begin
                        r_dec.hi      <= r_byte;
                        r_dec.pending <= 1'b1;
                     end else begin
                        r_dec.pending   <= 1'b0;
                        r_dec.pix_we    <= 1'b1;
                        r_dec.pix_color <= {r_dec.hi, r_byte};
                        r_dec.pix_x     <= r_dec.x;
                        r_dec.pix_y     <= r_dec.y;
                        if (r_dec.x == r_dec.col_end) begin
                           r_dec.x <= r_dec.col_start;
                           if (r_dec.y == r_dec.row_end) begin
                              r_dec.y          <= r_dec.row_start;
                              r_dec.frame_done <= 1'b1;
                           end else begin
                              r_dec.y <= w_y_inc;
                           end
                        end else begin
                           r_dec.x <= w_x_inc;
                        end
                     end
                  end
                  default: ;  // data bytes in IDLE are ignored
               endcase
            end
         end
      end
   end

   assign cmd_valid  = r_dec.cmd_valid;
   assign cmd_byte   = r_dec.cmd_byte;
   assign pix_we     = r_dec.pix_we;
   assign pix_x      = r_dec.pix_x;
   assign pix_y      = r_dec.pix_y;
   assign pix_color  = r_dec.pix_color;
   assign frame_done = r_dec.frame_done;

endmodule
